poll_tx: RTL and testbench

//  Upstream stage of the GameCube controller reader. It periodically drives the 24-bit poll command

---
 rtl/poll_tx.sv | 184 ++++++++++++++++++
 tb/tb_poll_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/poll_tx.sv
// poll_tx: periodic poll transmitter for the GameCube controller reader.
// Drives the 24-bit poll command plus a stop bit onto the open-drain line,
// then watches for the controller reply. It opens the reader's window with
// `ready`, reports the end of the reply, and flags a missing reply.
//
// Ports
//   PCLK        in   clock
//   PRESET      in   synchronous active-high reset
//   enable      in   level; keep polling while high
//   rumble      in   command LSB, sampled when a command starts
//   data_in     in   raw controller line (asynchronous, pulled up)
//   drive_low   out  1 = pull the line low, 0 = release
//   ready       out  reply window open for the reader
//   busy        out  transaction in progress (TX, wait, reply)
//   poll_done   out  1-cycle pulse, reply ended normally
//   timeout_err out  1-cycle pulse, no reply arrived
//   rx_edges    out  reply falling edges of the last transaction
module poll_tx #(
   parameter int unsigned CLKS_PER_US   = 100,
   parameter int unsigned GAP_CLKS      = 1000000,
   parameter int unsigned TIMEOUT_CLKS  = 2000,
   parameter int unsigned END_IDLE_BITS = 2
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       enable,
   input  logic       rumble,
   input  logic       data_in,
   output logic       drive_low,
   output logic       ready,
   output logic       busy,
   output logic       poll_done,
   output logic       timeout_err,
   output logic [6:0] rx_edges
);

   localparam int unsigned BitClks = 4 * CLKS_PER_US;
   localparam int unsigned EndClks = END_IDLE_BITS * BitClks;
   localparam int unsigned MaxA    = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
   localparam int unsigned MaxB    = (EndClks > BitClks) ? EndClks : BitClks;
   localparam int unsigned MaxCnt  = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned TW      = $clog2(MaxCnt + 1);

   localparam logic [TW-1:0] BitLast     = TW'(BitClks - 1);
   localparam logic [TW-1:0] LowOne      = TW'(CLKS_PER_US);
   localparam logic [TW-1:0] LowZero     = TW'(3 * CLKS_PER_US);
   localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CLKS - 1);
   localparam logic [TW-1:0] EndLast     = TW'(EndClks - 1);
   localparam logic [TW-1:0] GapLast     = TW'(GAP_CLKS - 1);
   localparam logic [23:0]   PollCmd     = 24'h400302;
   localparam logic [4:0]    StopIdx     = 5'd24;
   localparam logic [6:0]    EdgeMax     = 7'd127;

   typedef enum logic [2:0] {StIdle, StTx, StWaitResp, StRx, StGap} state_e;

   state_e      state_q, state_d;
   logic        sync1_q, sync_cur_q, sync_prev_q;
   // Shared timer: bit phase in TX, reply wait in WAIT_RESP, idle run in RX, gap in GAP.
   logic [TW-1:0] timer_q, timer_d;
   logic [4:0]  bit_q, bit_d;
   logic [23:0] cmd_q, cmd_d;
   logic [6:0]  edges_q, edges_d;
   logic        done_q, done_d;
   logic        to_q, to_d;

   logic fall;
   logic tx_bit;
   logic start_tx;

   assign fall     = sync_prev_q & ~sync_cur_q;
   assign start_tx = (state_d == StTx) && (state_q != StTx);

   // State register and datapath registers.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         sync1_q     <= 1'b1;
         sync_cur_q  <= 1'b1;
         sync_prev_q <= 1'b1;
         timer_q     <= '0;
         bit_q       <= '0;
         cmd_q       <= '0;
         edges_q     <= '0;
         done_q      <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= data_in;
         sync_cur_q  <= sync1_q;
         sync_prev_q <= sync_cur_q;
         timer_q     <= timer_d;
         bit_q       <= bit_d;
         cmd_q       <= cmd_d;
         edges_q     <= edges_d;
         done_q      <= done_d;
         to_q        <= to_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (enable) state_d = StTx;
         end
         StTx: begin
            if ((bit_q == StopIdx) && (timer_q == BitLast)) state_d = StWaitResp;
         end
         StWaitResp: begin
            if (fall) begin
               state_d = StRx;
            end else if (timer_q == TimeoutLast) begin
               state_d = StGap;
            end
         end
         StRx: begin
            // Timer counts consecutive synced-high cycles; end of reply when it fills.
            if (sync_cur_q && (timer_q == EndLast)) state_d = StGap;
         end
         StGap: begin
            if (timer_q == GapLast) state_d = enable ? StTx : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state.
   always_comb begin
      timer_d = timer_q + TW'(1);
      bit_d   = bit_q;
      cmd_d   = cmd_q;
      edges_d = edges_q;
      done_d  = 1'b0;
      to_d    = 1'b0;

      case (state_q)
         StIdle: begin
            timer_d = '0;
         end
         StTx: begin
            if (timer_q == BitLast) begin
               timer_d = '0;
               bit_d   = bit_q + 5'd1;
            end
         end
         StWaitResp: begin
            // The reply's first edge is counted here; the reader never sees it.
            if (fall) begin
               edges_d = 7'd1;
            end else if (state_d == StGap) begin
               to_d = 1'b1;
            end
         end
         StRx: begin
            if (fall && (edges_q != EdgeMax)) edges_d = edges_q + 7'd1;
            if (!sync_cur_q) timer_d = '0;
            if (state_d == StGap) done_d = 1'b1;
         end
         default: ;
      endcase

      if (state_d != state_q) timer_d = '0;

      if (start_tx) begin
         bit_d   = '0;
         cmd_d   = PollCmd | {23'b0, rumble};
         edges_d = '0;
      end
   end

   // Outputs.
   always_comb begin
      tx_bit      = (bit_q == StopIdx) ? 1'b1 : cmd_q[5'd23 - bit_q];
      drive_low   = 1'b0;
      if (state_q == StTx) drive_low = timer_q < (tx_bit ? LowOne : LowZero);
      ready       = (state_q == StRx);
      busy        = (state_q == StTx) || (state_q == StWaitResp) || (state_q == StRx);
      poll_done   = done_q;
      timeout_err = to_q;
      rx_edges    = edges_q;
   end

endmodule

// File: tb/tb_poll_tx.sv
// Scoreboard bench for poll_tx. Stimulus computes a timeline of expected
// drive_low pulses and transaction outcomes from the protocol rules and pushes
// them into queues; monitors pop and compare as the DUT produces them.
module tb_poll_tx;

   localparam int C        = 10;
   localparam int BIT      = 4 * C;
   localparam int TXC      = 25 * BIT;
   localparam int TO       = 200;
   localparam int GAP      = 500;
   localparam int ENDB     = 2;
   localparam int ENDC     = ENDB * BIT;
   localparam int SYNC_LAT = 2;

   logic       clk = 1'b0;
   logic       rst, enable, rumble, ctrl_low;
   logic       data_in;
   logic       drive_low, ready, busy, poll_done, timeout_err;
   logic [6:0] rx_edges;

   // Open-drain line: low if either side pulls it down.
   assign data_in = !(drive_low || ctrl_low);

   poll_tx #(
      .CLKS_PER_US  (C),
      .GAP_CLKS     (GAP),
      .TIMEOUT_CLKS (TO),
      .END_IDLE_BITS(ENDB)
   ) dut (
      .PCLK       (clk),
      .PRESET     (rst),
      .enable     (enable),
      .rumble     (rumble),
      .data_in    (data_in),
      .drive_low  (drive_low),
      .ready      (ready),
      .busy       (busy),
      .poll_done  (poll_done),
      .timeout_err(timeout_err),
      .rx_edges   (rx_edges)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int start;
      int len;
   } pulse_t;

   typedef struct {
      bit is_to;
      int edges;
      int ready_t;
      int end_t;
   } txn_t;

   pulse_t pulse_q[$];
   txn_t   txn_q[$];

   // drive_low pulse monitor
   logic   dl_prev = 1'b0;
   int     dl_start = 0;
   pulse_t pe;
   always @(negedge clk) begin
      if (drive_low === 1'b1 && !dl_prev) begin
         dl_start = cyc;
         check("busy_during_tx", int'(busy), 1);
      end
      if (drive_low === 1'b0 && dl_prev) begin
         if (pulse_q.size() == 0) begin
            check("unexpected_drive_pulse", dl_start, -1);
         end else begin
            pe = pulse_q.pop_front();
            check("bit_start", dl_start, pe.start);
            check("bit_low_len", cyc - dl_start, pe.len);
         end
      end
      dl_prev = (drive_low === 1'b1);
   end

   // ready / end-of-transaction monitor
   logic rdy_prev = 1'b0;
   int   ready_t  = -1;
   txn_t te;
   always @(negedge clk) begin
      if (ready === 1'b1 && !rdy_prev) begin
         check("ready_single_rise", ready_t, -1);
         ready_t = cyc;
      end
      rdy_prev = (ready === 1'b1);
      if (poll_done === 1'b1 || timeout_err === 1'b1) begin
         if (txn_q.size() == 0) begin
            check("unexpected_end_pulse", cyc, -1);
         end else begin
            te = txn_q.pop_front();
            check("end_is_timeout", int'(timeout_err), int'(te.is_to));
            check("end_is_done", int'(poll_done), int'(!te.is_to));
            check("end_time", cyc, te.end_t);
            check("rx_edges", int'(rx_edges), te.edges);
            check("ready_rise_time", ready_t, te.ready_t);
            check("ready_low_at_end", int'(ready), 0);
            check("busy_low_at_end", int'(busy), 0);
         end
         ready_t = -1;
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected low time of each transmitted bit, MSB first, stop bit last.
   task automatic push_tx(input int start, input bit rmb, input int nbits);
      logic [23:0] cmd;
      bit          b;
      cmd = 24'h400302 | {23'b0, rmb};
      for (int i = 0; i < nbits; i++) begin
         b = (i == 24) ? 1'b1 : cmd[23 - i];
         pulse_q.push_back('{start + i * BIT, b ? C : 3 * C});
      end
   endtask

   // Controller model: nbits random data bits plus a stop bit, from cycle r.
   task automatic reply(input int r, input int nbits);
      bit v;
      for (int i = 0; i <= nbits; i++) begin
         v = (i == nbits) ? 1'b1 : 1'($urandom_range(0, 1));
         wait_until(r + i * BIT);
         ctrl_low = 1'b1;
         wait_until(r + i * BIT + (v ? C : 3 * C));
         ctrl_low = 1'b0;
      end
   endtask

   // nbits = 0 means the controller stays silent.
   task automatic do_txn(input int start, input bit rmb, input int nbits, input bit drop_en,
                         output int next_start);
      int tx_end, r, last_rise, end_t, edges;
      wait_until(start - 1);
      rumble = rmb;
      enable = 1'b1;
      push_tx(start, rmb, 25);
      tx_end = start + TXC;
      if (nbits == 0) begin
         end_t = tx_end + TO;
         txn_q.push_back('{1'b1, 0, -1, end_t});
         wait_until(end_t);
      end else begin
         r         = tx_end + 2 * C;
         last_rise = r + nbits * BIT + C;
         end_t     = last_rise + SYNC_LAT + ENDC;
         edges     = (nbits + 1 > 127) ? 127 : nbits + 1;
         txn_q.push_back('{1'b0, edges, r + SYNC_LAT + 1, end_t});
         reply(r, nbits);
         if (drop_en) begin
            wait_until(last_rise + 5);
            enable = 1'b0;
         end
         wait_until(end_t);
      end
      next_start = end_t + GAP;
   endtask

   int nxt, s5, s10;
   bit r5;

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      rumble   = 1'b0;
      ctrl_low = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_drive_low", int'(drive_low), 0);
      check("rst_ready", int'(ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_poll_done", int'(poll_done), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
      check("rst_rx_edges", int'(rx_edges), 0);
      rst = 1'b0;
      wait_until(10);

      do_txn(11, 1'b0, 64, 1'b0, nxt);                           // full reply
      do_txn(nxt, 1'b1, 0, 1'b0, nxt);                           // no reply
      do_txn(nxt, 1'($urandom_range(0, 1)), 10, 1'b0, nxt);      // short reply
      do_txn(nxt, 1'($urandom_range(0, 1)), 130, 1'b0, nxt);     // saturating count

      // Reset while bit 10 (a 0) is being driven low.
      s5 = nxt;
      r5 = 1'($urandom_range(0, 1));
      wait_until(s5 - 1);
      rumble = r5;
      push_tx(s5, r5, 10);
      s10 = s5 + 10 * BIT;
      pulse_q.push_back('{s10, 6});
      wait_until(s10 + 5);
      rst = 1'b1;
      wait_until(s10 + 6);
      check("midrst_drive_low", int'(drive_low), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_ready", int'(ready), 0);
      wait_until(s10 + 8);
      rst = 1'b0;

      // Restart from bit 0, then drop enable during the reply.
      do_txn(s10 + 9, 1'($urandom_range(0, 1)), 64, 1'b1, nxt);
      wait_until(nxt + 200);
      check("final_busy", int'(busy), 0);
      check("final_drive_low", int'(drive_low), 0);
      check("held_rx_edges", int'(rx_edges), 65);
      check("pending_pulses", pulse_q.size(), 0);
      check("pending_txns", txn_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
